// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back select pipe.
package wb_pkg;

  typedef enum logic [1:0] {
    LS_WORD = 2'd0,
    LS_HALF = 2'd1,
    LS_BYTE = 2'd2,
    LS_RSVD = 2'd3
  } load_size_e;

  localparam int WB_DEF_WIDTH   = 32;
  localparam int WB_DEF_NUM_SRC = 8;

endpackage

// File: rtl/writeback_select_pipe_if.sv
// Source/handshake bundle between the datapath sources, the write-back pipe
// and the register-file write port.
interface writeback_select_pipe_if import wb_pkg::*; #(
  parameter int WIDTH   = WB_DEF_WIDTH,
  parameter int NUM_SRC = WB_DEF_NUM_SRC,
  parameter int SEL_W   = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0][WIDTH-1:0] SrcData;
  logic [SEL_W-1:0]              MemtoReg;
  load_size_e                    LoadSize;
  logic                          LoadSigned;
  logic [1:0]                    ByteOffset;
  logic                          InValid;
  logic                          InReady;
  logic [WIDTH-1:0]              WriteData;
  logic                          OutValid;
  logic                          OutReady;

  modport master (
    output SrcData, MemtoReg, LoadSize, LoadSigned, ByteOffset, InValid, OutReady,
    input  InReady, WriteData, OutValid
  );

  modport slave (
    input  SrcData, MemtoReg, LoadSize, LoadSigned, ByteOffset, InValid, OutReady,
    output InReady, WriteData, OutValid
  );
endinterface

// File: rtl/wb_load_extract.sv
// Combinational sub-word load formatter (little-endian lanes).
// Only compiled when WB_LOAD_EXT_EN is defined.
`ifdef WB_LOAD_EXT_EN
module wb_load_extract import wb_pkg::*; #(
  parameter int WIDTH = WB_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  load_size_e       LoadSize,
  input  logic             LoadSigned,
  input  logic [1:0]       ByteOffset,
  output logic [WIDTH-1:0] result
);

  logic [31:0] word_lane;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  function automatic logic [WIDTH-1:0] extend8(input logic [7:0] v, input logic sgn);
    logic [WIDTH-1:0] r;
    r      = {WIDTH{sgn & v[7]}};
    r[7:0] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] extend16(input logic [15:0] v, input logic sgn);
    logic [WIDTH-1:0] r;
    r       = {WIDTH{sgn & v[15]}};
    r[15:0] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] extend32(input logic [31:0] v, input logic sgn);
    logic [WIDTH-1:0] r;
    r       = {WIDTH{sgn & v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  always_comb begin
    word_lane = data[31:0];
    byte_lane = word_lane[{ByteOffset, 3'b000} +: 8];
    half_lane = word_lane[{ByteOffset[1], 4'b0000} +: 16];
    result    = extend32(word_lane, LoadSigned);
    unique case (LoadSize)
      LS_BYTE: result = extend8(byte_lane, LoadSigned);
      LS_HALF: result = extend16(half_lane, LoadSigned);
      default: result = extend32(word_lane, LoadSigned);
    endcase
  end

endmodule
`endif

// File: rtl/writeback_select_pipe.sv
// Registered write-back source selector with a two-entry valid/ready skid buffer.
// Optional sub-word load extraction on MEM_SRC when WB_LOAD_EXT_EN is defined.
module writeback_select_pipe import wb_pkg::*; #(
  parameter int WIDTH   = WB_DEF_WIDTH,
  parameter int NUM_SRC = WB_DEF_NUM_SRC,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int MEM_SRC = 1
) (
  input logic                    Clk,
  input logic                    Reset_n,
  writeback_select_pipe_if.slave bus
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] fmt_data;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             out_valid;
  logic             skid_full;
  logic             in_fire;
  logic             out_free;

  // Out-of-range selects match no entry and fall back to source 0.
  always_comb begin
    sel_data = bus.SrcData[0];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (bus.MemtoReg == SEL_W'(i)) sel_data = bus.SrcData[i];
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic             mem_sel;
  logic [WIDTH-1:0] ext_data;

  assign mem_sel = (bus.MemtoReg == SEL_W'(MEM_SRC));

  wb_load_extract #(.WIDTH(WIDTH)) u_load_extract (
    .data       (sel_data),
    .LoadSize   (bus.LoadSize),
    .LoadSigned (bus.LoadSigned),
    .ByteOffset (bus.ByteOffset),
    .result     (ext_data)
  );

  assign fmt_data = mem_sel ? ext_data : sel_data;
`else
  assign fmt_data = sel_data;
`endif

  assign in_fire  = bus.InValid && !skid_full;
  assign out_free = !out_valid || bus.OutReady;

  // Skid stage: out_reg feeds the consumer, skid_reg catches the beat in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      out_reg   <= '0;
      skid_reg  <= '0;
    end else if (out_free) begin
      if (skid_full) begin
        out_reg   <= skid_reg;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_fire) begin
        out_reg   <= fmt_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_reg  <= fmt_data;
      skid_full <= 1'b1;
    end
  end

  assign bus.InReady   = !skid_full;
  assign bus.OutValid  = out_valid;
  assign bus.WriteData = out_reg;

endmodule
